fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the front end.
- Owns the fetch PC and issues one instruction-memory read at a time.
- Pushes returned instructions, with their PC and PC+4, into the instruction queue.
- Handles backpressure from a full queue, and redirects from branch resolution or flush; a redirect squashes any in-flight or buffered fetch.

Parameters:
- RESET_PC, 32'h60000000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  load new fetch PC and squash in-flight work
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced to 0
- imem_addr  out  32  read address; equals the current fetch PC
- imem_rmask  out  4  4'hF on a request cycle, else 4'h0
- imem_rdata  in  32  read data; valid when imem_resp=1
- imem_resp  in  1  single-cycle response strobe
- iq_full  in  1  instruction queue cannot accept this cycle
- iq_enq  out  1  enqueue strobe
- iq_inst  out  32  instruction being enqueued
- iq_pc  out  32  PC of the enqueued instruction
- iq_pc_next  out  32  iq_pc + 4, modulo 2^32

Behaviour:
- State: pc (32), state (S_REQ, S_WAIT, S_HOLD), discard (1), buf_inst (32).
- Reset values: pc=RESET_PC, state=S_REQ, discard=0, buf_inst=0.
- While rst=1: imem_rmask=0 and iq_enq=0.
- The instruction memory shares rst; no response to a pre-reset request is delivered after reset.
- Only one request is outstanding at any time.
- S_REQ:
  - Drive imem_rmask=4'hF and imem_addr=pc for exactly one cycle; next state is S_WAIT.
  - If redirect_valid: pc<=redirect_pc and discard<=1, because the request just issued is already committed.
- S_WAIT (imem_rmask=0):
  - No resp, no redirect: hold.
  - No resp, redirect: pc<=redirect_pc, discard<=1, stay in S_WAIT.
  - resp with discard=1: drop the data, discard<=0, go to S_REQ. A redirect in the same cycle still updates pc.
  - resp, discard=0, redirect_valid=1: drop the data, pc<=redirect_pc, go to S_REQ.
  - resp, discard=0, no redirect, iq_full=0:
    - Assert iq_enq the same cycle with iq_inst=imem_rdata, iq_pc=pc, iq_pc_next=pc+4 (combinational from resp).
    - pc<=pc+4; go to S_REQ.
  - resp, discard=0, no redirect, iq_full=1: buf_inst<=imem_rdata; go to S_HOLD.
- S_HOLD (imem_rmask=0):
  - redirect_valid: drop the buffer, pc<=redirect_pc, go to S_REQ.
  - Else if iq_full=0: iq_enq=1 with iq_inst=buf_inst, iq_pc=pc, iq_pc_next=pc+4; pc<=pc+4; go to S_REQ.
  - Else hold.
- Priority: rst > redirect_valid > enqueue.
- iq_enq is never asserted in the same cycle as redirect_valid.
- iq_enq is never asserted while iq_full=1.
- PC wrap: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag.
- Outside iq_enq cycles, iq_inst, iq_pc and iq_pc_next are don't-care.
- Throughput: with a 1-cycle memory and a non-full queue, one instruction every 2 cycles.
- A reset asserted in any state returns the block to its reset values on the next edge; discard and the buffer are cleared.

Test Plan:
- Basic streaming: release reset; memory answers 1 cycle after each request; iq_full=0.
  -> Requests go out at 0x60000000, 0x60000004, 0x60000008.
  -> Enqueues carry matching iq_pc and iq_pc_next=iq_pc+4, spaced 2 cycles apart.
- Queue full: hold iq_full=1 across the resp for 0x60000000, then release 3 cycles later.
  -> No enqueue and no new request while full; enqueue of the buffered data on the release cycle.
  -> Next request goes to 0x60000004.
- Redirect while waiting: assert redirect_valid with redirect_pc=0x60000100 during S_WAIT.
  -> The later response is dropped (no iq_enq).
  -> Next request goes to 0x60000100, and it enqueues with iq_pc=0x60000100.
- Redirect on the request or response cycle:
  - redirect_valid coincident with imem_rmask=4'hF -> that response is discarded.
  - redirect_valid coincident with imem_resp -> no enqueue that cycle.
  - Both cases: the next request goes to redirect_pc.
  - redirect_pc=0x60000203 -> the request is issued to 0x60000200.
- Redirect while holding: in S_HOLD with iq_full=1, redirect to 0x60000040, then drop iq_full.
  -> The buffered instruction is never enqueued; the first enqueue has iq_pc=0x60000040.
- Reset mid-operation and wrap:
  - Assert rst during S_WAIT -> imem_rmask=0 and iq_enq=0 while rst=1; the first request after release goes to 0x60000000.
  - Redirect to 0xFFFFFFFC -> enqueue shows iq_pc_next=0x00000000, and the next request goes to 0x00000000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: owns the fetch PC, keeps one imem read in flight and feeds the
// instruction queue. A redirect squashes whatever fetch is in flight or buffered.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        iq_full,
   output logic        iq_enq,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   output logic [31:0] iq_pc_next
);

   typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] redirect_pc_aligned;
   logic [31:0] pc_plus4;

   assign redirect_pc_aligned = redirect_pc & ~32'h3;
   assign pc_plus4            = pc_q + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StReq;
         pc_q       <= RESET_PC;
         discard_q  <= 1'b0;
         buf_inst_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         discard_q  <= discard_d;
         buf_inst_q <= buf_inst_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      discard_d  = discard_q;
      buf_inst_d = buf_inst_q;
      imem_addr  = pc_q;
      imem_rmask = 4'h0;
      iq_enq     = 1'b0;
      iq_inst    = imem_rdata;
      iq_pc      = pc_q;
      iq_pc_next = pc_plus4;

      unique case (state_q)
         StReq: begin
            imem_rmask = 4'hF;
            state_d    = StWait;
            // The request is already committed, so its response must be dropped.
            if (redirect_valid) begin
               pc_d      = redirect_pc_aligned;
               discard_d = 1'b1;
            end
         end
         StWait: begin
            if (imem_resp) begin
               state_d = StReq;
               if (discard_q) begin
                  discard_d = 1'b0;
                  if (redirect_valid) pc_d = redirect_pc_aligned;
               end else if (redirect_valid) begin
                  pc_d = redirect_pc_aligned;
               end else if (!iq_full) begin
                  iq_enq = 1'b1;
                  pc_d   = pc_plus4;
               end else begin
                  buf_inst_d = imem_rdata;
                  state_d    = StHold;
               end
            end else if (redirect_valid) begin
               pc_d      = redirect_pc_aligned;
               discard_d = 1'b1;
            end
         end
         StHold: begin
            iq_inst = buf_inst_q;
            if (redirect_valid) begin
               pc_d    = redirect_pc_aligned;
               state_d = StReq;
            end else if (!iq_full) begin
               iq_enq  = 1'b1;
               pc_d    = pc_plus4;
               state_d = StReq;
            end
         end
         default: state_d = StReq;
      endcase

      if (rst) begin
         imem_rmask = 4'h0;
         iq_enq     = 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a behavioural memory plus a transaction-level fetch model predict every
// request and enqueue; directed scenarios then check the logged traffic against fixed values.
module tb_fetch_ctrl;
   localparam logic [31:0] RESET_PC = 32'h6000_0000;

   logic        clk = 1'b0;
   logic        rst, redirect_valid, imem_resp, iq_full, iq_enq;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, iq_inst, iq_pc, iq_pc_next;
   logic [3:0]  imem_rmask;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
      .imem_resp(imem_resp), .iq_full(iq_full), .iq_enq(iq_enq), .iq_inst(iq_inst),
      .iq_pc(iq_pc), .iq_pc_next(iq_pc_next)
   );

   int total = 0, bad = 0, cyc = 0;

   // Model: next fetch address, an outstanding read (live unless squashed), a parked instruction.
   logic [31:0] m_pc = RESET_PC, m_buf_inst = '0;
   bit          m_out = 0, m_live = 0, m_buf = 0;

   bit          mem_pending = 0;
   logic [31:0] mem_addr = '0;
   int          mem_cnt = 0, mem_lat = 0;

   logic [31:0] req_addr_q[$], enq_pc_q[$], enq_nx_q[$];
   int          req_cyc_q[$], enq_cyc_q[$];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic cycle(input bit r, input bit rv, input logic [31:0] rpc, input bit full);
      logic [31:0] apc, exp_inst;
      bit          exp_req, exp_enq;
      rst = r; redirect_valid = rv; redirect_pc = rpc; iq_full = full;
      imem_resp  = mem_pending && mem_cnt == 0;
      imem_rdata = imem_resp ? inst_of(mem_addr) : $urandom;
      #2;
      apc      = rpc & ~32'h3;
      exp_req  = !r && !m_out && !m_buf;
      exp_enq  = 0;
      exp_inst = '0;
      if (!r) begin
         if (m_buf) begin
            exp_enq = !rv && !full; exp_inst = m_buf_inst;
         end else if (m_out && imem_resp && m_live && !rv && !full) begin
            exp_enq = 1; exp_inst = imem_rdata;
         end
      end
      total++;
      if (imem_rmask !== (exp_req ? 4'hF : 4'h0)) begin
         bad++; $display("FAIL rmask cyc=%0d got=%h exp=%h", cyc, imem_rmask, exp_req ? 4'hF : 4'h0);
      end
      if (exp_req) begin
         total++;
         if (imem_addr !== m_pc) begin
            bad++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
         end
      end
      total++;
      if (iq_enq !== exp_enq) begin
         bad++; $display("FAIL iq_enq cyc=%0d got=%b exp=%b", cyc, iq_enq, exp_enq);
      end
      if (exp_enq) begin
         total++;
         if (iq_inst !== exp_inst || iq_pc !== m_pc || iq_pc_next !== m_pc + 32'd4) begin
            bad++;
            $display("FAIL enq_fields cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, iq_inst, iq_pc,
                     iq_pc_next, exp_inst, m_pc, m_pc + 32'd4);
         end
      end
      if (imem_rmask === 4'hF) begin req_addr_q.push_back(imem_addr); req_cyc_q.push_back(cyc); end
      if (iq_enq === 1'b1) begin
         enq_pc_q.push_back(iq_pc); enq_nx_q.push_back(iq_pc_next); enq_cyc_q.push_back(cyc);
      end
      if (r) begin
         m_pc = RESET_PC; m_out = 0; m_live = 0; m_buf = 0;
      end else if (exp_req) begin
         m_out = 1; m_live = !rv;
         if (rv) m_pc = apc;
      end else if (m_out) begin
         if (imem_resp) begin
            m_out = 0;
            if (rv) m_pc = apc;
            else if (m_live) begin
               if (full) begin m_buf = 1; m_buf_inst = imem_rdata; end
               else m_pc = m_pc + 32'd4;
            end
         end else if (rv) begin
            m_pc = apc; m_live = 0;
         end
      end else if (m_buf) begin
         if (rv) begin m_buf = 0; m_pc = apc; end
         else if (!full) begin m_buf = 0; m_pc = m_pc + 32'd4; end
      end
      // Memory shares reset and answers mem_lat idle cycles after the request cycle.
      if (r) mem_pending = 0;
      else begin
         if (imem_resp) mem_pending = 0;
         else if (mem_pending) mem_cnt--;
         if (imem_rmask === 4'hF) begin
            mem_pending = 1; mem_addr = imem_addr; mem_cnt = mem_lat;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic do_reset();
      cycle(1, 0, '0, 0);
      cycle(1, 0, '0, 0);
      req_addr_q.delete(); req_cyc_q.delete();
      enq_pc_q.delete(); enq_nx_q.delete(); enq_cyc_q.delete();
      cyc = 0;
   endtask

   task automatic test_reset();
      do_reset();
      cycle(0, 0, '0, 0);
      total++;
      if (req_addr_q.size() != 1 || req_addr_q[0] !== RESET_PC) begin
         bad++; $display("FAIL reset_first_req got_n=%0d exp_addr=%h", req_addr_q.size(), RESET_PC);
      end
   endtask

   task automatic test_stream();
      do_reset(); mem_lat = 0;
      repeat (7) cycle(0, 0, '0, 0);
      total++;
      if (req_addr_q.size() < 3 || req_addr_q[0] !== 32'h6000_0000 ||
          req_addr_q[1] !== 32'h6000_0004 || req_addr_q[2] !== 32'h6000_0008) begin
         bad++; $display("FAIL stream_reqs got_n=%0d exp=60000000,04,08", req_addr_q.size());
      end
      total++;
      if (enq_pc_q.size() != 3 || enq_pc_q[2] !== 32'h6000_0008 || enq_nx_q[2] !== 32'h6000_000c ||
          enq_cyc_q[1] - enq_cyc_q[0] != 2 || enq_cyc_q[2] - enq_cyc_q[1] != 2) begin
         bad++; $display("FAIL stream_enq got_n=%0d exp=3 spaced 2", enq_pc_q.size());
      end
   endtask

   task automatic test_queue_full();
      do_reset(); mem_lat = 0;
      cycle(0, 0, '0, 0);
      repeat (3) cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 0);
      total++;
      if (enq_cyc_q.size() != 1 || enq_cyc_q[0] != 4 || enq_pc_q[0] !== 32'h6000_0000) begin
         bad++; $display("FAIL full_enq got_n=%0d exp one enq at cycle 4", enq_cyc_q.size());
      end
      total++;
      if (req_addr_q.size() != 2 || req_cyc_q[1] != 5 || req_addr_q[1] !== 32'h6000_0004) begin
         bad++; $display("FAIL full_next_req got_n=%0d exp 60000004 at cycle 5", req_addr_q.size());
      end
   endtask

   task automatic test_redirect_wait();
      do_reset(); mem_lat = 2;
      for (int i = 0; i < 9; i++) cycle(0, i == 1, 32'h6000_0100, 0);
      total++;
      if (req_addr_q.size() < 2 || req_addr_q[1] !== 32'h6000_0100) begin
         bad++; $display("FAIL wait_redir_req got_n=%0d exp 60000100", req_addr_q.size());
      end
      total++;
      if (enq_pc_q.size() < 1 || enq_pc_q[0] !== 32'h6000_0100 || enq_cyc_q[0] != 7) begin
         bad++; $display("FAIL wait_redir_enq got_n=%0d exp pc 60000100 at cycle 7", enq_pc_q.size());
      end
   endtask

   task automatic test_redirect_req_resp();
      do_reset(); mem_lat = 0;
      for (int i = 0; i < 4; i++) cycle(0, i == 0, 32'h6000_0203, 0);
      total++;
      if (req_addr_q.size() < 2 || req_addr_q[1] !== 32'h6000_0200 || enq_pc_q.size() != 1 ||
          enq_pc_q[0] !== 32'h6000_0200 || enq_cyc_q[0] != 3) begin
         bad++; $display("FAIL redir_on_req got_n=%0d exp req/enq at 60000200", enq_pc_q.size());
      end
      do_reset();
      for (int i = 0; i < 4; i++) cycle(0, i == 1, 32'h6000_0300, 0);
      total++;
      if (req_addr_q.size() < 2 || req_addr_q[1] !== 32'h6000_0300 || enq_pc_q.size() != 1 ||
          enq_pc_q[0] !== 32'h6000_0300 || enq_cyc_q[0] != 3) begin
         bad++; $display("FAIL redir_on_resp got_n=%0d exp req/enq at 60000300", enq_pc_q.size());
      end
   endtask

   task automatic test_redirect_hold();
      do_reset(); mem_lat = 0;
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 1);
      cycle(0, 1, 32'h6000_0040, 1);
      repeat (3) cycle(0, 0, '0, 0);
      total++;
      if (enq_pc_q.size() != 1 || enq_pc_q[0] !== 32'h6000_0040 || req_addr_q.size() < 2 ||
          req_addr_q[1] !== 32'h6000_0040) begin
         bad++; $display("FAIL hold_redir got_n=%0d exp first enq 60000040", enq_pc_q.size());
      end
   endtask

   task automatic test_reset_wrap();
      do_reset(); mem_lat = 2;
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 0);
      cycle(1, 0, '0, 0);
      cycle(1, 0, '0, 0);
      mem_lat = 0;
      cycle(0, 1, 32'hFFFF_FFFC, 0);
      repeat (4) cycle(0, 0, '0, 0);
      total++;
      if (req_addr_q.size() != 4 || req_cyc_q[1] != 4 || req_addr_q[1] !== RESET_PC) begin
         bad++; $display("FAIL mid_reset_req got_n=%0d exp 60000000 at cycle 4", req_addr_q.size());
      end
      total++;
      if (enq_pc_q.size() != 1 || enq_pc_q[0] !== 32'hFFFF_FFFC || enq_nx_q[0] !== 32'h0) begin
         bad++; $display("FAIL wrap_enq got_n=%0d exp pc fffffffc next 00000000", enq_pc_q.size());
      end
      total++;
      if (req_addr_q.size() != 4 || req_addr_q[3] !== 32'h0) begin
         bad++; $display("FAIL wrap_req got_n=%0d exp 00000000", req_addr_q.size());
      end
   endtask

   task automatic test_random();
      logic [31:0] rpc;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         mem_lat = $urandom_range(0, 3);
         rpc = $urandom;
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 2) == 0);
      end
      total++;
      if (enq_pc_q.size() < 100) begin
         bad++; $display("FAIL random_progress got=%0d exp>=100 enqueues", enq_pc_q.size());
      end
   endtask

   initial begin
      rst = 1; redirect_valid = 0; redirect_pc = '0; iq_full = 0; imem_resp = 0; imem_rdata = '0;
      test_reset();
      test_stream();
      test_queue_full();
      test_redirect_wait();
      test_redirect_req_resp();
      test_redirect_hold();
      test_reset_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
